// File: rtl/mopshub_rec_pkg.sv
// rtl/mopshub_rec_pkg.sv - shared types, widths and round-robin search for the MOPSHUB receive arbiter
package mopshub_rec_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      WAIT_DATA
   } arb_state_t;

   localparam int N_BUS    = 32;
   localparam int MSG_W    = 76;
   localparam int BUS_ID_W = 5;

   // First eligible index after last, wrapping modulo N_BUS; last itself is checked last.
   function automatic logic [BUS_ID_W-1:0] rr_next(input logic [BUS_ID_W-1:0] last,
                                                   input logic [N_BUS-1:0]    eligible);
      logic [BUS_ID_W-1:0] idx;
      logic                found;
      rr_next = last;
      found   = 1'b0;
      for (int i = 1; i <= N_BUS; i++) begin
         idx = last + BUS_ID_W'(i);
         if (!found && eligible[idx]) begin
            rr_next = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rec_msg_fifo.sv
// rtl/rec_msg_fifo.sv - first-word-fall-through message buffer with full/empty/count
module rec_msg_fifo #(
   parameter int WIDTH = 76,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_CNT);
   assign o_count   = r_count;
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mopshub_rec_arbiter.sv
// rtl/mopshub_rec_arbiter.sv - round-robin receive arbiter from 32 CAN controllers into the uplink FIFO
module mopshub_rec_arbiter
   import mopshub_rec_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [4:0]          i_n_buses,
   input  logic [N_BUS-1:0]    i_irq_can_rec,
   output logic [4:0]          o_can_rec_select,
   output logic                o_rec_ack,
   input  logic [MSG_W-1:0]    i_data_rec_in,
   input  logic                i_data_rec_valid,
   output logic [MSG_W-1:0]    o_data_rec_uplink,
   output logic                o_uplink_valid,
   input  logic                i_uplink_ready,
   output logic                o_fifo_full,
   output logic                o_timeout_err,
   output logic [4:0]          o_timeout_bus_id,
   output logic [7:0]          o_drop_cnt
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

   arb_state_t            r_state;
   arb_state_t            w_state_nxt;
   logic [BUS_ID_W-1:0]   r_select;
   logic [BUS_ID_W-1:0]   r_last_grant;
   logic [BUS_ID_W-1:0]   r_tmo_bus;
   logic [CNT_W-1:0]      r_tmo_cnt;
   logic [7:0]            r_drop_cnt;

   logic [N_BUS-1:0]      w_eligible;
   logic [BUS_ID_W-1:0]   w_pick;
   logic                  w_any;
   logic                  w_tmo_hit;
   logic                  w_ack;
   logic                  w_push;
   logic                  w_tmo;
   logic                  w_has_room;
   logic                  w_full;
   logic                  w_empty;
   logic [FCW-1:0]        w_count;

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < N_BUS; i++) begin
         w_eligible[i] = i_irq_can_rec[i] & (BUS_ID_W'(i) <= i_n_buses);
      end
   end

   assign w_any      = |w_eligible;
   assign w_pick     = rr_next(r_last_grant, w_eligible);
   assign w_tmo_hit  = (r_tmo_cnt == CNT_W'(TIMEOUT));
   assign w_has_room = (w_count < FCW'(FIFO_DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_ack       = 1'b0;
      w_push      = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_has_room && w_any) w_state_nxt = ACK;
         end
         ACK: begin
            w_ack       = 1'b1;
            w_state_nxt = WAIT_DATA;
         end
         WAIT_DATA: begin
            // Data arriving on the timeout cycle still counts as delivered.
            if (i_data_rec_valid) begin
               w_push      = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_tmo_hit) begin
               w_tmo       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= IDLE;
         r_select     <= '0;
         r_last_grant <= BUS_ID_W'(N_BUS - 1);
         r_tmo_cnt    <= '0;
         r_tmo_bus    <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_state_nxt == ACK) r_select <= w_pick;
         if (r_state == ACK) begin
            r_tmo_cnt <= '0;
         end else if (r_state == WAIT_DATA && !i_data_rec_valid && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
         // A timed-out bus also becomes last_grant so it goes to the back of the queue.
         if (w_push || w_tmo) r_last_grant <= r_select;
         if (w_tmo) r_tmo_bus <= r_select;
         if (i_data_rec_valid && r_state != WAIT_DATA && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   rec_msg_fifo #(
      .WIDTH (MSG_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (i_data_rec_in),
      .i_pop   (i_uplink_ready),
      .o_data  (o_data_rec_uplink),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign o_can_rec_select = r_select;
   assign o_rec_ack        = w_ack;
   assign o_uplink_valid   = ~w_empty;
   assign o_fifo_full      = w_full;
   assign o_timeout_err    = w_tmo;
   assign o_timeout_bus_id = r_tmo_bus;
   assign o_drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_mopshub_rec_arbiter.sv
// tb/tb_mopshub_rec_arbiter.sv - scoreboard bench for mopshub_rec_arbiter with a modelled CAN-side responder
module tb_mopshub_rec_arbiter;
   import mopshub_rec_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  n_buses;
   logic [31:0] irq;
   logic [4:0]  sel;
   logic        ack;
   logic [75:0] din;
   logic        dvalid;
   logic [75:0] up_data;
   logic        up_valid;
   logic        up_ready;
   logic        full;
   logic        terr;
   logic [4:0]  tbus;
   logic [7:0]  drops;

   always #5 clk = ~clk;

   mopshub_rec_arbiter dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_n_buses         (n_buses),
      .i_irq_can_rec     (irq),
      .o_can_rec_select  (sel),
      .o_rec_ack         (ack),
      .i_data_rec_in     (din),
      .i_data_rec_valid  (dvalid),
      .o_data_rec_uplink (up_data),
      .o_uplink_valid    (up_valid),
      .i_uplink_ready    (up_ready),
      .o_fifo_full       (full),
      .o_timeout_err     (terr),
      .o_timeout_bus_id  (tbus),
      .o_drop_cnt        (drops)
   );

   int          n_vec  = 0;
   int          n_miss = 0;
   int          cyc    = 0;
   logic [75:0] exp_q[$];
   int          grants[$];
   int          resp_cd = 0;
   int          resp_delay;
   logic [4:0]  resp_bus;
   logic [31:0] resp_mask;
   bit          resp_clear;
   bit          drove;
   bit          ack_seen;
   int          ack_cyc;
   int          last_ack_bus;
   bit          use_fixed;
   logic [75:0] fixed_msg;
   logic [63:0] serial = 64'h0;

   task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive the responder, log grants, score pops, then advance to the next negedge.
   task automatic step();
      logic [75:0] m;
      if (drove) begin
         dvalid = 1'b0;
         drove  = 1'b0;
      end
      if (resp_cd > 0) begin
         resp_cd--;
         if (resp_cd == 0) begin
            m = use_fixed ? fixed_msg : {4'hB, 3'b000, resp_bus, serial};
            serial++;
            din    = m;
            dvalid = 1'b1;
            drove  = 1'b1;
            exp_q.push_back(m);
            if (resp_clear) irq[resp_bus] = 1'b0;
         end
      end
      if (ack) begin
         grants.push_back(int'(sel));
         ack_seen     = 1'b1;
         ack_cyc      = cyc;
         last_ack_bus = int'(sel);
         if (resp_mask[sel] && resp_delay > 0) begin
            resp_cd  = resp_delay;
            resp_bus = sel;
         end
      end
      if (up_valid && up_ready) begin
         if (exp_q.size() == 0) chk("pop_without_expected", up_valid, 1'b0);
         else chk("uplink_data", up_data, exp_q.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_ack(input int max, input string tag);
      ack_seen = 1'b0;
      for (int i = 0; i < max && !ack_seen; i++) step();
      chk({tag, "_ack_seen"}, ack_seen, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int exp_rr[6] = '{5, 31, 0, 5, 31, 0};
      int exp_bp[6] = '{6, 9, 12, 15, 18, 1};
      rst = 1'b0; n_buses = 5'd31; irq = '0; din = '0; dvalid = 1'b0; up_ready = 1'b0;
      resp_mask = '1; resp_delay = 1; resp_clear = 1'b1; use_fixed = 1'b0;
      fixed_msg = 76'hA_5555_1234; drove = 1'b0; ack_seen = 1'b0;
      @(negedge clk);
      chk("rst_sel", sel, 0);
      chk("rst_ack", ack, 0);
      chk("rst_valid", up_valid, 0);
      chk("rst_data", up_data, 0);
      chk("rst_full", full, 0);
      chk("rst_terr", terr, 0);
      chk("rst_tbus", tbus, 0);
      chk("rst_drops", drops, 0);
      step(); step();
      rst = 1'b1;
      step();

      // single request, bus answers 3 cycles after ack
      use_fixed = 1'b1; resp_delay = 3;
      irq[2] = 1'b1;
      t0 = cyc;
      wait_ack(10, "t1");
      chk("t1_sel", last_ack_bus, 2);
      chk("t1_ack_latency", ack_cyc, t0 + 1);
      for (int i = 0; i < 10 && !up_valid; i++) step();
      chk("t1_visible_cycle", cyc, ack_cyc + 4);
      chk("t1_data", up_data, 76'hA_5555_1234);
      up_ready = 1'b1;
      step(); step();
      chk("t1_drained", up_valid, 0);
      chk("t1_ack_count", grants.size(), 1);
      use_fixed = 1'b0; resp_delay = 1; grants.delete();

      // round robin over 0, 5, 31 with requests held
      resp_clear = 1'b0;
      irq = 32'h8000_0021;
      for (int i = 0; i < 200 && grants.size() < 6; i++) step();
      irq = '0;
      repeat (10) step();
      chk("rr_count", grants.size(), 6);
      for (int k = 0; k < 6 && k < grants.size(); k++) chk($sformatf("rr_grant%0d", k), grants[k], exp_rr[k]);
      chk("rr_drained", up_valid, 0);
      grants.delete();

      // masking: bus 4 lies above n_buses
      n_buses = 5'd3;
      irq = 32'h0000_0014;
      for (int i = 0; i < 100 && grants.size() < 4; i++) step();
      irq = '0;
      repeat (10) step();
      chk("mask_count", grants.size(), 4);
      for (int k = 0; k < 4 && k < grants.size(); k++) chk($sformatf("mask_grant%0d", k), grants[k], 2);
      n_buses = 5'd31;
      grants.delete();

      // backpressure: six requesters, four-deep FIFO
      resp_clear = 1'b1;
      up_ready = 1'b0;
      irq = (32'h1 << 1) | (32'h1 << 6) | (32'h1 << 9) | (32'h1 << 12) | (32'h1 << 15) | (32'h1 << 18);
      repeat (60) step();
      chk("bp_acks_while_full", grants.size(), 4);
      chk("bp_full", full, 1);
      chk("bp_valid", up_valid, 1);
      up_ready = 1'b1;
      repeat (40) step();
      chk("bp_total_grants", grants.size(), 6);
      for (int k = 0; k < 6 && k < grants.size(); k++) chk($sformatf("bp_grant%0d", k), grants[k], exp_bp[k]);
      chk("bp_sb_empty", exp_q.size(), 0);
      chk("bp_full_cleared", full, 0);
      grants.delete();

      // timeout: bus 7 never answers
      resp_mask = ~(32'h1 << 7);
      irq = 32'h1 << 7;
      wait_ack(10, "to");
      chk("to_sel", last_ack_bus, 7);
      irq[3] = 1'b1;
      for (int i = 0; i < 400 && !terr; i++) step();
      chk("to_latency", cyc - ack_cyc, 256);
      chk("to_err", terr, 1);
      step();
      chk("to_pulse_len", terr, 0);
      chk("to_bus_id", tbus, 7);
      wait_ack(10, "to_next");
      chk("to_next_bus", last_ack_bus, 3);
      resp_mask = '1;
      wait_ack(10, "to_again");
      chk("to_again_bus", last_ack_bus, 7);
      repeat (10) step();
      chk("to_sb_empty", exp_q.size(), 0);
      grants.delete();

      // stray valid in IDLE
      irq = '0;
      for (int k = 0; k < 3; k++) begin
         din = 76'h123;
         dvalid = 1'b1;
         step();
         dvalid = 1'b0;
         step();
      end
      chk("drop_cnt", drops, 3);
      chk("drop_fifo_empty", up_valid, 0);
      chk("drop_no_grant", grants.size(), 0);

      // reset in WAIT_DATA
      resp_mask = ~(32'h1 << 20);
      irq = 32'h1 << 20;
      wait_ack(10, "rs");
      chk("rs_sel", last_ack_bus, 20);
      repeat (3) step();
      rst = 1'b0;
      #1;
      chk("rs_sel_cleared", sel, 0);
      chk("rs_ack", ack, 0);
      chk("rs_valid", up_valid, 0);
      chk("rs_full", full, 0);
      chk("rs_terr", terr, 0);
      chk("rs_tbus", tbus, 0);
      chk("rs_drops", drops, 0);
      resp_cd = 0; exp_q.delete(); resp_mask = '1;
      irq = (32'h1 << 4) | (32'h1 << 30);
      @(negedge clk);
      rst = 1'b1;
      wait_ack(10, "rs_release");
      chk("rs_first_grant", last_ack_bus, 4);
      irq = '0;
      repeat (10) step();
      chk("rs_sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
